pwm_audio_demod: RTL and testbench
==================================

// Module: pwm_audio_demod
// PURPOSE
//  Receive end of the PWM audio link: recovers the N-bit duty value from a serial PWM stream.
//  Input format: period 2^N clocks; pin high for the first D cycles of each period, then low.
//  D = 0 gives no high cycles. Output is one duty sample per period, plus lock/error status.
//  Sits after the board pad / loopback, feeding the filter datapath.
// PARAMETERS
//  N          4   duty width in bits; frame length = 2^N clocks
// PORTS
//  clk         in   1  system clock, same frequency as the transmitter
//  reset       in   1  one clock; reset is synchronous and active-high
//  pwm_in      in   1  PWM stream, asynchronous to clk
//  duty_out    out  N  last recovered duty value, held between updates
//  duty_valid  out  1  one-clock pulse when duty_out updates
//  locked      out  1  high while frame alignment is established
//  frame_err   out  1  one-clock pulse on misaligned edge or saturated frame
// BEHAVIOUR
//  Reset:
//   - duty_out=0, duty_valid=0, locked=0, frame_err=0.
//   - state=SEARCH; sync flops, s_d, win_cnt and hi_cnt all cleared.
//  Input conditioning:
//   - pwm_in passes through a 2-FF synchronizer to give s; s_d is s delayed by one clock.
//   - rise = s & ~s_d. Input-to-s latency is 2 clocks.
//  Counters:
//   - win_cnt: N bits, wraps naturally.
//   - hi_cnt: N+1 bits, so a full-high window (count 2^N) is representable.
//  SEARCH:
//   - Hold all outputs; locked=0.
//   - On rise: win_cnt<=1, hi_cnt<=1, go to ACQUIRE.
//  ACQUIRE / LOCKED, every clock:
//   - win_cnt<=win_cnt+1.
//   - While win_cnt!=0: hi_cnt<=hi_cnt+s.
//  Window boundary (win_cnt==0, i.e. current s is the first sample of a new frame):
//   - duty_out<=sat(hi_cnt), where sat clamps 2^N to 2^N-1; duty_valid<=1; hi_cnt<=s.
//   - If saturated: frame_err<=1.
//   - ACQUIRE->LOCKED; locked asserts with the same edge as the first duty_valid.
//  Misaligned rise (win_cnt!=0) in ACQUIRE or LOCKED:
//   - frame_err<=1, locked<=0, win_cnt<=1, hi_cnt<=1, go to ACQUIRE.
//   - No duty_valid for the partial frame.
//  Idle input in LOCKED:
//   - With no edges (D=0), keep free-running and emit duty_out=0 every 2^N clocks.
//   - Lock is held.
//  Priority when misaligned rise and boundary coincide:
//   - Impossible by definition: a rise at win_cnt==0 is aligned.
//  Reset mid-frame:
//   - Partial accumulation is discarded; outputs return to reset values the next clock.
//  Timing:
//   - duty_valid rate: once per 2^N clocks while locked.
//   - Latency: 2^N+3 clocks from first pwm_in high of a frame to its duty_valid.
// STRUCTURE
//  Shared package pwm_audio_pkg:
//   - typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} demod_state_t.
//   - Default N, shared with the transmitter.
//  Sub-module sync_2ff: generic single-bit 2-FF synchronizer, reset to 0.
//  Remainder is a single FSM plus counters in this module.
// TESTING (N=4, 16-clock frames, stimulus from the pwm_audio transmitter in loopback)
//  1. reset 4 clks, duty 8 -> locked rises with first duty_valid; duty_out=8 every 16 clks; no frame_err.
//  2. duty 8->2->14, 32 clks each -> duty_out sequence 8,..,2,..,14; transitional frame value is old or new, never other.
//  3. lock at duty 5, then duty 0 for 64 clks -> duty_out=0 each frame; locked stays 1.
//  4. pwm_in forced high 48 clks after lock -> duty_out=15 with frame_err pulses; no X, no wrap to 0.
//  5. 1-clk glitch high at win_cnt=7 mid-frame -> frame_err pulse, locked=0; relock after next clean frame, value correct.
//  6. reset asserted at win_cnt=9 for 2 clks -> all outputs 0 next clk; SEARCH; relocks normally afterwards.

Source files
------------

// File: rtl/pwm_audio_pkg.sv
// Shared definitions for the PWM audio link (transmitter and receiver).
// Holds the default duty width and the receiver's frame-alignment states.
package pwm_audio_pkg;

  localparam int unsigned DefaultN = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } demod_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pwm_audio_demod.sv
// PWM audio receiver: aligns to the frame-start rising edge and counts high samples per
// 2^N-clock window, emitting one duty sample per frame plus lock and error status.
module pwm_audio_demod
  import pwm_audio_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_in,
  output logic [N-1:0] duty_out,
  output logic         duty_valid,
  output logic         locked,
  output logic         frame_err
);

  demod_state_t state_q, state_d;
  logic         s;
  logic         s_d_q;
  logic         rise;
  logic         boundary;
  logic [N-1:0] win_q, win_d;
  logic [N:0]   hi_q, hi_d;
  logic [N-1:0] duty_q, duty_d;
  logic [N-1:0] sat_hi;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  sync_2ff u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (pwm_in),
    .q_o     (s)
  );

  assign rise     = s & ~s_d_q;
  assign boundary = (win_q == '0);
  // A full-high window counts 2^N, which does not fit the duty width.
  assign sat_hi   = hi_q[N] ? {N{1'b1}} : hi_q[N-1:0];

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    hi_d    = hi_q;
    duty_d  = duty_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (rise) begin
          win_d   = N'(1);
          hi_d    = (N+1)'(1);
          state_d = ACQUIRE;
        end
      end
      ACQUIRE, LOCKED: begin
        if (boundary) begin
          duty_d  = sat_hi;
          valid_d = 1'b1;
          err_d   = hi_q[N];
          hi_d    = (N+1)'(s);
          win_d   = win_q + N'(1);
          state_d = LOCKED;
        end else if (rise) begin
          // Edge inside the window: realign to it and drop the partial frame.
          err_d   = 1'b1;
          win_d   = N'(1);
          hi_d    = (N+1)'(1);
          state_d = ACQUIRE;
        end else begin
          win_d = win_q + N'(1);
          hi_d  = hi_q + (N+1)'(s);
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
      s_d_q   <= 1'b0;
      win_q   <= '0;
      hi_q    <= '0;
      duty_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_d_q   <= s;
      win_q   <= win_d;
      hi_q    <= hi_d;
      duty_q  <= duty_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign duty_out   = duty_q;
  assign duty_valid = valid_q;
  assign frame_err  = err_q;
  assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_pwm_audio_demod.sv
// Bench for pwm_audio_demod: loopback-style PWM frames, glitches and resets, checked every
// cycle against a window-history model plus a few literal expectations.
module tb_pwm_audio_demod;

  localparam int unsigned N     = 4;
  localparam int          Frame = 16;

  logic         clk;
  logic         reset;
  logic         pwm_in;
  logic [N-1:0] duty_out;
  logic         duty_valid;
  logic         locked;
  logic         frame_err;

  int n_cmp;
  int n_bad;
  int cyc;

  // Model: sync pipeline, alignment age and per-position sample history of the current window.
  bit     mvalid;
  bit     m_p1, m_s, m_sd;
  int     m_state;
  int     m_age;
  bit     hist[Frame];
  int     e_duty;
  bit     e_valid, e_err, e_locked;

  // DUT-side observations for the literal checks.
  int dut_valid_cnt;
  int dut_err_cnt;
  int dut_last_duty;
  int first_valid_cyc;

  pwm_audio_demod #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .duty_valid (duty_valid),
    .locked     (locked),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < Frame; i++) hist[i] = 1'b0;
  endtask

  // Predict the outputs after the next clock edge from the currently applied inputs.
  task automatic model_step();
    bit rise;
    int pos;
    int sum;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (reset) begin
      mvalid  = 1'b1;
      m_p1    = 1'b0;
      m_s     = 1'b0;
      m_sd    = 1'b0;
      m_state = 0;
      m_age   = 0;
      clear_hist();
      e_duty   = 0;
      e_locked = 1'b0;
    end else begin
      rise = m_s && !m_sd;
      if (m_state == 0) begin
        if (rise) begin
          m_state = 1;
          m_age   = 0;
          clear_hist();
          hist[0] = 1'b1;
        end
      end else begin
        m_age = m_age + 1;
        pos   = m_age % Frame;
        if (pos == 0) begin
          sum = 0;
          for (int i = 0; i < Frame; i++) sum += int'(hist[i]);
          e_duty  = (sum >= Frame) ? Frame - 1 : sum;
          e_err   = (sum >= Frame);
          e_valid = 1'b1;
          m_state = 2;
          clear_hist();
          hist[0] = m_s;
        end else if (rise) begin
          e_err   = 1'b1;
          m_state = 1;
          m_age   = 0;
          clear_hist();
          hist[0] = 1'b1;
        end else begin
          hist[pos] = m_s;
        end
      end
      e_locked = (m_state == 2);
      m_sd = m_s;
      m_s  = m_p1;
      m_p1 = pwm_in;
    end
  endtask

  // Compare process: outputs of the previous edge, then step the model for the next one.
  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        check("duty_out", 32'(duty_out), 32'(e_duty));
        check("duty_valid", 32'(duty_valid), 32'(e_valid));
        check("locked", 32'(locked), 32'(e_locked));
        check("frame_err", 32'(frame_err), 32'(e_err));
      end
      if (duty_valid === 1'b1) begin
        dut_valid_cnt = dut_valid_cnt + 1;
        dut_last_duty = int'(duty_out);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (frame_err === 1'b1) dut_err_cnt = dut_err_cnt + 1;
      model_step();
    end
  end

  // One transmitter frame: high for the first d clocks; d=Frame means high throughout.
  task automatic send_frame(input int d, input int glitch);
    for (int p = 0; p < Frame; p++) begin
      @(posedge clk);
      #2;
      pwm_in = (p < d) || (p == glitch);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #3;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    reset  = 1'b1;
    pwm_in = 1'b0;
    for (int i = 0; i < n; i++) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  int c0;
  int errs0;
  int r;
  int d;
  int g;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    mvalid = 1'b0;
    dut_valid_cnt = 0; dut_err_cnt = 0; dut_last_duty = -1; first_valid_cyc = -1;
    e_duty = 0; e_valid = 0; e_err = 0; e_locked = 0;
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #3;
    check("reset_duty", 32'(duty_out), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_valid", 32'(duty_valid), 32'd0);

    // 1: steady duty 8, plus first-frame latency.
    idle(3);
    @(posedge clk);
    #2;
    c0     = cyc;
    pwm_in = 1'b1;
    for (int p = 1; p < Frame; p++) begin
      @(posedge clk);
      #2;
      pwm_in = (p < 8);
    end
    repeat (4) send_frame(8, -1);
    idle(4);
    check("latency", 32'(first_valid_cyc - c0), 32'(Frame + 3));
    check("t1_duty", 32'(dut_last_duty), 32'd8);
    check("t1_locked", 32'(locked), 32'd1);
    check("t1_no_err", 32'(dut_err_cnt), 32'd0);

    // 2: duty steps 8 -> 2 -> 14.
    repeat (2) send_frame(8, -1);
    repeat (2) send_frame(2, -1);
    repeat (2) send_frame(14, -1);
    idle(4);
    check("t2_duty", 32'(dut_last_duty), 32'd14);

    // 3: lock at 5, then idle low for 64 clocks.
    repeat (3) send_frame(5, -1);
    repeat (4) send_frame(0, -1);
    idle(4);
    check("t3_duty", 32'(dut_last_duty), 32'd0);
    check("t3_locked", 32'(locked), 32'd1);

    // 4: pin stuck high for three frames.
    errs0 = dut_err_cnt;
    repeat (3) send_frame(Frame, -1);
    idle(4);
    check("t4_duty", 32'(dut_last_duty), 32'd15);
    check("t4_err", 32'(dut_err_cnt - errs0), 32'd3);
    repeat (3) send_frame(8, -1);

    // 5: one-clock glitch at window position 7.
    repeat (2) send_frame(3, -1);
    errs0 = dut_err_cnt;
    send_frame(3, 7);
    check("t5_unlock", 32'(locked), 32'd0);
    repeat (2) send_frame(3, -1);
    idle(4);
    check("t5_err", 32'(dut_err_cnt - errs0), 32'd2);
    check("t5_relock", 32'(locked), 32'd1);
    check("t5_duty", 32'(dut_last_duty), 32'd3);

    // 6: reset for two clocks at window position 9.
    repeat (2) send_frame(6, -1);
    for (int p = 0; p < Frame; p++) begin
      @(posedge clk);
      #2;
      pwm_in = (p < 6);
      reset  = (p == 9) || (p == 10);
      if (p == 11) begin
        @(negedge clk);
        check("t6_duty", 32'(duty_out), 32'd0);
        check("t6_locked", 32'(locked), 32'd0);
      end
    end
    repeat (3) send_frame(6, -1);
    idle(4);
    check("t6_relock", 32'(locked), 32'd1);
    check("t6_duty_after", 32'(dut_last_duty), 32'd6);

    // Randomized frames with occasional stuck-high, glitches and resets.
    for (int f = 0; f < 250; f++) begin
      r = $urandom_range(0, 99);
      d = (r < 5) ? Frame : $urandom_range(0, Frame - 1);
      g = -1;
      if (r >= 5 && r < 13 && d + 2 <= Frame - 1) g = $urandom_range(d + 2, Frame - 1);
      if (r == 99) do_reset($urandom_range(1, 3));
      send_frame(d, g);
    end
    idle(Frame + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
